uart_tx_buffer: RTL and testbench

Buffers words from the CPU/debug side and hands them one at a time to the UART transmitter. Holds up to 2^DEPTH_LOG2 pending words in a FIFO. Issues a single-cycle start pulse per word, then waits for the transmitter's done pulse before releasing the next word. Sits directly upstream of the UART transmitter, on the same clock.

---
 rtl/uart_pkg.sv | 13 +
 rtl/sync_fifo.sv | 64 ++++++
 rtl/uart_tx_buffer.sv | 115 +++++++++++
 tb/tb_uart_tx_buffer.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared FSM state encoding and default widths for the UART transmit buffer.
package uart_pkg;

  localparam int DEFAULT_DATA_BITS  = 32;
  localparam int DEFAULT_DEPTH_LOG2 = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    START = 2'b01,
    WAIT  = 2'b10
  } tx_state_t;

endpackage

// File: rtl/sync_fifo.sv
// Parameterised single-clock FIFO: storage array, wrapping pointers, word count and flags.
module sync_fifo
  import uart_pkg::*;
#(
  parameter int DATA_BITS  = DEFAULT_DATA_BITS,
  parameter int DEPTH_LOG2 = DEFAULT_DEPTH_LOG2
) (
  input  logic                  i_clk,
  input  logic                  i_reset_n,
  input  logic                  i_wr_en,
  input  logic [DATA_BITS-1:0]  i_wr_data,
  input  logic                  i_rd_en,
  output logic [DATA_BITS-1:0]  o_rd_data,
  output logic                  o_full,
  output logic                  o_empty,
  output logic [DEPTH_LOG2:0]   o_level
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] FULL_COUNT = (DEPTH_LOG2 + 1)'(DEPTH);

  logic [DATA_BITS-1:0]  mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr_reg;
  logic [DEPTH_LOG2-1:0] rd_ptr_reg;
  logic [DEPTH_LOG2:0]   count_reg;
  logic                  wr_accept;
  logic                  rd_accept;

  // A write into a full FIFO is dropped even when a pop frees a slot in the same cycle.
  assign wr_accept = i_wr_en && !o_full;
  assign rd_accept = i_rd_en && !o_empty;

  always_ff @(posedge i_clk) begin
    if (wr_accept) begin
      mem[wr_ptr_reg] <= i_wr_data;
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (wr_accept) begin
        wr_ptr_reg <= wr_ptr_reg + DEPTH_LOG2'(1);
      end
      if (rd_accept) begin
        rd_ptr_reg <= rd_ptr_reg + DEPTH_LOG2'(1);
      end
      case ({wr_accept, rd_accept})
        2'b10:   count_reg <= count_reg + (DEPTH_LOG2 + 1)'(1);
        2'b01:   count_reg <= count_reg - (DEPTH_LOG2 + 1)'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

  assign o_rd_data = mem[rd_ptr_reg];
  assign o_full    = (count_reg == FULL_COUNT);
  assign o_empty   = (count_reg == '0);
  assign o_level   = count_reg;

endmodule

// File: rtl/uart_tx_buffer.sv
// Buffers CPU words and releases them one at a time to the UART transmitter.
// Optional sticky overflow flag is enabled with UART_TX_BUFFER_OVF_EN.
module uart_tx_buffer
  import uart_pkg::*;
#(
  parameter int DATA_BITS  = DEFAULT_DATA_BITS,
  parameter int DEPTH_LOG2 = DEFAULT_DEPTH_LOG2
) (
  input  logic                  i_clk,
  input  logic                  i_reset_n,
  input  logic                  i_wr_en,
  input  logic [DATA_BITS-1:0]  i_wr_data,
  output logic                  o_full,
  output logic                  o_empty,
  output logic [DEPTH_LOG2:0]   o_level,
  output logic                  o_tx_start,
  output logic [DATA_BITS-1:0]  o_tx_data,
  input  logic                  i_tx_done,
  output logic                  o_busy
`ifdef UART_TX_BUFFER_OVF_EN
  ,
  output logic                  o_overflow,
  input  logic                  i_ovf_clr
`endif
);

  tx_state_t            state_reg;
  tx_state_t            state_next;
  logic                 pop;
  logic [DATA_BITS-1:0] fifo_rd_data;
  logic [DATA_BITS-1:0] tx_data_reg;
  logic                 fifo_full;
  logic                 fifo_empty;

  sync_fifo #(
    .DATA_BITS  (DATA_BITS),
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) u_fifo (
    .i_clk     (i_clk),
    .i_reset_n (i_reset_n),
    .i_wr_en   (i_wr_en),
    .i_wr_data (i_wr_data),
    .i_rd_en   (pop),
    .o_rd_data (fifo_rd_data),
    .o_full    (fifo_full),
    .o_empty   (fifo_empty),
    .o_level   (o_level)
  );

  assign o_full  = fifo_full;
  assign o_empty = fifo_empty;

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Done pulses outside WAIT are ignored; the transmitter cannot legally finish a word it has not started.
  always_comb begin
    state_next = state_reg;
    pop        = 1'b0;
    case (state_reg)
      IDLE: begin
        if (!fifo_empty) begin
          pop        = 1'b1;
          state_next = START;
        end
      end
      START: begin
        state_next = WAIT;
      end
      WAIT: begin
        if (i_tx_done) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      tx_data_reg <= '0;
    end else if (pop) begin
      tx_data_reg <= fifo_rd_data;
    end
  end

  assign o_tx_data  = tx_data_reg;
  assign o_tx_start = (state_reg == START);
  assign o_busy     = (state_reg == START) || (state_reg == WAIT);

`ifdef UART_TX_BUFFER_OVF_EN
  logic overflow_reg;

  // Set takes priority so a drop in the clearing cycle is never lost.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      overflow_reg <= 1'b0;
    end else if (i_wr_en && fifo_full) begin
      overflow_reg <= 1'b1;
    end else if (i_ovf_clr) begin
      overflow_reg <= 1'b0;
    end
  end

  assign o_overflow = overflow_reg;
`endif

endmodule

// File: tb/tb_uart_tx_buffer.sv
// Scoreboard bench for uart_tx_buffer: accepted words are queued and checked at each start pulse.
module tb_uart_tx_buffer;

  localparam int DW    = 32;
  localparam int DL    = 4;
  localparam int DEPTH = 1 << DL;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          wr_en = 1'b0;
  logic [DW-1:0] wr_data = '0;
  logic          tx_done = 1'b0;
  logic          full;
  logic          empty;
  logic [DL:0]   level;
  logic          tx_start;
  logic [DW-1:0] tx_data;
  logic          busy;
`ifdef UART_TX_BUFFER_OVF_EN
  logic          overflow;
  logic          ovf_clr = 1'b0;
`endif

  int vectors = 0;
  int miscompares = 0;
  int start_count = 0;
  logic [DW-1:0] sb_q[$];

  always #5 clk = ~clk;

  uart_tx_buffer #(
    .DATA_BITS  (DW),
    .DEPTH_LOG2 (DL)
  ) dut (
    .i_clk      (clk),
    .i_reset_n  (rst_n),
    .i_wr_en    (wr_en),
    .i_wr_data  (wr_data),
    .o_full     (full),
    .o_empty    (empty),
    .o_level    (level),
    .o_tx_start (tx_start),
    .o_tx_data  (tx_data),
    .i_tx_done  (tx_done),
    .o_busy     (busy)
`ifdef UART_TX_BUFFER_OVF_EN
    ,
    .o_overflow (overflow),
    .i_ovf_clr  (ovf_clr)
`endif
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Every start pulse must carry the oldest word the bench expects to be transmitted.
  always @(negedge clk) begin
    if (rst_n && tx_start) begin
      start_count++;
      check("sb_nonempty_at_start", sb_q.size() != 0, 1);
      if (sb_q.size() != 0) begin
        check("tx_data", tx_data, sb_q.pop_front());
      end
    end
  end

  task automatic write_word(input logic [DW-1:0] d, input bit accept);
    wr_en   = 1'b1;
    wr_data = d;
    if (accept) sb_q.push_back(d);
    tick();
    wr_en   = 1'b0;
    $display("write %08h accept=%0d level=%0d", d, accept, level);
  endtask

  task automatic done_pulse(input int exp_level);
    tx_done = 1'b1;
    tick();
    tx_done = 1'b0;
    check("start_low_at_done", tx_start, 0);
    check("busy_low_at_done", busy, 0);
    tick();
    check("start_2cyc_after_done", tx_start, 1);
    check("level_after_pop", level, exp_level);
    $display("done -> start data=%08h level=%0d", tx_data, level);
  endtask

  task automatic done_idle();
    tx_done = 1'b1;
    tick();
    tx_done = 1'b0;
    check("busy_low_final", busy, 0);
    tick();
    check("no_start_when_empty", tx_start, 0);
    check("empty_final", empty, 1);
    $display("done -> idle level=%0d", level);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_start"}, tx_start, 0);
    check({tag, "_data"}, tx_data, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_full"}, full, 0);
    check({tag, "_empty"}, empty, 1);
    check({tag, "_level"}, level, 0);
`ifdef UART_TX_BUFFER_OVF_EN
    check({tag, "_ovf"}, overflow, 0);
`endif
  endtask

  initial begin
    // Reset state, then idle with nothing written.
    repeat (3) tick();
    check_reset_values("rst");
    rst_n = 1'b1;
    repeat (5) tick();
    check("idle_empty", empty, 1);
    check("idle_level", level, 0);
    check("idle_no_start", start_count, 0);

    // Single word: start two cycles after the write edge.
    write_word(32'hDEADBEEF, 1'b1);
    check("w1_level", level, 1);
    check("w1_empty", empty, 0);
    check("w1_start_n", tx_start, 0);
    tick();
    check("w1_start", tx_start, 1);
    check("w1_busy", busy, 1);
    check("w1_level_popped", level, 0);
    tick();
    check("w1_start_once", tx_start, 0);
    check("w1_busy_wait", busy, 1);

    // Three words queued behind the in-flight one.
    write_word(32'hA0000001, 1'b1);
    check("q_level1", level, 1);
    write_word(32'hB0000002, 1'b1);
    check("q_level2", level, 2);
    write_word(32'hC0000003, 1'b1);
    check("q_level3", level, 3);
    repeat (5) tick();
    check("no_second_start", start_count, 1);
    done_pulse(2);
    // A done pulse landing in START must not end the transfer.
    tx_done = 1'b1;
    tick();
    tx_done = 1'b0;
    repeat (3) tick();
    check("done_in_start_ignored", busy, 1);
    repeat (100) tick();
    done_pulse(1);
    repeat (100) tick();
    done_pulse(0);
    repeat (100) tick();
    done_idle();
    check("starts_after_burst", start_count, 4);

    // Fill behind an in-flight word, then overflow.
    write_word(32'h00000100, 1'b1);
    tick();
    tick();
    for (int i = 0; i < DEPTH; i++) write_word(32'h00000200 + i, 1'b1);
    check("fill_level", level, DEPTH);
    check("fill_full", full, 1);
    write_word(32'h00000011, 1'b0);
    check("ovf_level", level, DEPTH);
    check("ovf_full", full, 1);
`ifdef UART_TX_BUFFER_OVF_EN
    check("ovf_set", overflow, 1);
    repeat (3) tick();
    check("ovf_sticky", overflow, 1);
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    check("ovf_cleared", overflow, 0);
    wr_en = 1'b1;
    wr_data = 32'h00000033;
    ovf_clr = 1'b1;
    tick();
    wr_en = 1'b0;
    ovf_clr = 1'b0;
    check("ovf_set_wins", overflow, 1);
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
`endif

    // Full FIFO: pop and write in the same cycle, write dropped.
    tx_done = 1'b1;
    tick();
    tx_done = 1'b0;
    wr_en   = 1'b1;
    wr_data = 32'h00000022;
    tick();
    wr_en   = 1'b0;
    check("popwr_level", level, DEPTH - 1);
    check("popwr_full", full, 0);
    check("popwr_start", tx_start, 1);
`ifdef UART_TX_BUFFER_OVF_EN
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
`endif
    for (int k = DEPTH - 2; k >= 0; k--) begin
      repeat (3) tick();
      done_pulse(k);
    end
    repeat (3) tick();
    done_idle();
    check("sb_drained", sb_q.size(), 0);
    check("starts_after_fill", start_count, 21);

    // Reset while waiting with five words queued.
    write_word(32'h00000300, 1'b1);
    tick();
    tick();
    for (int i = 1; i <= 5; i++) write_word(32'h00000300 + i, 1'b0);
    check("pre_rst_level", level, 5);
    check("pre_rst_busy", busy, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_values("midrst");
    sb_q.delete();
    repeat (3) tick();
    rst_n = 1'b1;
    repeat (20) tick();
    check("post_rst_no_start", start_count, 22);
    check("post_rst_empty", empty, 1);
    check("post_rst_level", level, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
